// File: rtl/vmem_seq_if.sv
// Memory-side bus of the vector core: one address, read/write strobes and
// separate write/read data paths. DataIn is valid the cycle after RD.
interface vmem_seq_if #(
  parameter int AW = 16,
  parameter int EW = 16
);
  logic [AW-1:0] Addr;
  logic          RD;
  logic          WR;
  logic [EW-1:0] dataOut;
  logic [EW-1:0] DataIn;

  modport master (
    output Addr,
    output RD,
    output WR,
    output dataOut,
    input  DataIn
  );

  modport slave (
    input  Addr,
    input  RD,
    input  WR,
    input  dataOut,
    output DataIn
  );
endinterface

// File: rtl/vmem_seq.sv
// Memory-port sequencer/arbiter: shares the 16-bit bus between instruction
// fetch and vector load/store, splitting a VLD/VST into ELEMS element transfers.
//
// state        | meaning
// -------------+--------------------------------------------------------------
// S_IDLE       | bus quiet, vready=1; vreq beats fetch_req
// S_FETCH      | fetch read issued at captured address
// S_FETCH_RESP | DataIn returned to the fetch requester
// S_VLOAD      | read element k; capture element k-1 from DataIn
// S_VLOAD_TAIL | no strobe; capture last element
// S_VSTORE     | write element k
// S_DONE       | vdone pulse
module vmem_seq #(
  parameter int ELEMS = 16,
  parameter int EW    = 16,
  parameter int AW    = 16
) (
  input  logic                Clk1,
  input  logic                Reset,
  input  logic                fetch_req,
  input  logic [AW-1:0]       fetch_addr,
  output logic                fetch_gnt,
  output logic                fetch_valid,
  output logic [EW-1:0]       fetch_data,
  input  logic                vreq,
  input  logic                vwrite,
  input  logic [AW-1:0]       vbase,
  input  logic [ELEMS*EW-1:0] vwdata,
  output logic                vready,
  output logic                vdone,
  output logic [ELEMS*EW-1:0] vrdata,
  vmem_seq_if.master          mem
);

  localparam int KW = $clog2(ELEMS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_RESP,
    S_VLOAD,
    S_VLOAD_TAIL,
    S_VSTORE,
    S_DONE
  } state_t;

  state_t              state;
  logic [KW-1:0]       k_q;
  logic [AW-1:0]       base_q;
  logic [ELEMS*EW-1:0] store_q;
  logic [ELEMS*EW-1:0] vrdata_q;
  logic [AW-1:0]       addr_q;
  logic                rd_q;
  logic                wr_q;
  logic [EW-1:0]       dout_q;
  logic                vdone_q;
  logic                fvalid_q;

  logic [KW-1:0]       k_nxt;
  logic [KW-1:0]       k_prev;
  logic                last_k;
  logic [AW-1:0]       addr_nxt;

  assign k_nxt    = k_q + 1'b1;
  assign k_prev   = k_q - 1'b1;
  assign last_k   = (k_q == KW'(ELEMS - 1));
  assign addr_nxt = base_q + AW'(k_nxt);

  // Grant is combinational so the requester can drop fetch_req the same cycle.
  assign fetch_gnt   = Reset && (state == S_IDLE) && fetch_req && !vreq;
  assign vready      = (state == S_IDLE);
  assign fetch_valid = fvalid_q;
  assign fetch_data  = fvalid_q ? mem.DataIn : '0;
  assign vdone       = vdone_q;
  assign vrdata      = vrdata_q;

  assign mem.Addr    = addr_q;
  assign mem.RD      = rd_q;
  assign mem.WR      = wr_q;
  assign mem.dataOut = dout_q;

  always_ff @(posedge Clk1 or negedge Reset) begin
    if (!Reset) begin
      state    <= S_IDLE;
      k_q      <= '0;
      base_q   <= '0;
      store_q  <= '0;
      vrdata_q <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      dout_q   <= '0;
      vdone_q  <= 1'b0;
      fvalid_q <= 1'b0;
    end else begin
      vdone_q  <= 1'b0;
      fvalid_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (vreq) begin
            base_q <= vbase;
            k_q    <= '0;
            addr_q <= vbase;
            if (vwrite) begin
              wr_q    <= 1'b1;
              dout_q  <= vwdata[EW-1:0];
              store_q <= vwdata >> EW;
              state   <= S_VSTORE;
            end else begin
              rd_q  <= 1'b1;
              state <= S_VLOAD;
            end
          end else if (fetch_req) begin
            addr_q <= fetch_addr;
            rd_q   <= 1'b1;
            state  <= S_FETCH;
          end
        end
        S_FETCH: begin
          rd_q     <= 1'b0;
          addr_q   <= '0;
          fvalid_q <= 1'b1;
          state    <= S_FETCH_RESP;
        end
        S_FETCH_RESP: begin
          state <= S_IDLE;
        end
        S_VLOAD: begin
          // DataIn now carries the element read one cycle earlier.
          if (k_q != '0) begin
            vrdata_q[k_prev*EW +: EW] <= mem.DataIn;
          end
          if (last_k) begin
            rd_q   <= 1'b0;
            addr_q <= '0;
            state  <= S_VLOAD_TAIL;
          end else begin
            addr_q <= addr_nxt;
          end
          k_q <= k_nxt;
        end
        S_VLOAD_TAIL: begin
          vrdata_q[(ELEMS-1)*EW +: EW] <= mem.DataIn;
          vdone_q <= 1'b1;
          state   <= S_DONE;
        end
        S_VSTORE: begin
          if (last_k) begin
            wr_q    <= 1'b0;
            addr_q  <= '0;
            dout_q  <= '0;
            vdone_q <= 1'b1;
            state   <= S_DONE;
          end else begin
            addr_q  <= addr_nxt;
            dout_q  <= store_q[EW-1:0];
            store_q <= store_q >> EW;
          end
          k_q <= k_nxt;
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vmem_seq.sv
// Bench for vmem_seq: transaction-level schedule model plus directed and
// randomized fetch / VLD / VST traffic against a 64K-word memory.
module tb_vmem_seq;
  localparam int ELEMS = 16;
  localparam int EW    = 16;
  localparam int AW    = 16;

  logic                Clk1 = 1'b0;
  logic                Reset = 1'b0;
  logic                fetch_req = 1'b0;
  logic [AW-1:0]       fetch_addr = '0;
  logic                fetch_gnt;
  logic                fetch_valid;
  logic [EW-1:0]       fetch_data;
  logic                vreq = 1'b0;
  logic                vwrite = 1'b0;
  logic [AW-1:0]       vbase = '0;
  logic [ELEMS*EW-1:0] vwdata = '0;
  logic                vready;
  logic                vdone;
  logic [ELEMS*EW-1:0] vrdata;

  vmem_seq_if #(.AW(AW), .EW(EW)) bus ();

  vmem_seq #(.ELEMS(ELEMS), .EW(EW), .AW(AW)) dut (
    .Clk1        (Clk1),
    .Reset       (Reset),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_gnt   (fetch_gnt),
    .fetch_valid (fetch_valid),
    .fetch_data  (fetch_data),
    .vreq        (vreq),
    .vwrite      (vwrite),
    .vbase       (vbase),
    .vwdata      (vwdata),
    .vready      (vready),
    .vdone       (vdone),
    .vrdata      (vrdata),
    .mem         (bus)
  );

  always #5 Clk1 = ~Clk1;

  logic [15:0] mem_arr [0:65535];
  logic [15:0] ref_mem [0:65535];

  // Synchronous memory; junk on DataIn whenever no read was issued.
  always @(posedge Clk1) begin
    bus.DataIn <= bus.RD ? mem_arr[bus.Addr] : 16'($urandom);
    if (bus.WR) mem_arr[bus.Addr] = bus.dataOut;
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(string name, logic [255:0] got, logic [255:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endfunction

  // Expected bus cycle, one per clock while a transaction is outstanding.
  typedef struct {
    logic        rd;
    logic        wr;
    logic        vd;
    logic        fv;
    logic        chk_vr;
    logic        ld_done;
    logic [15:0] addr;
    logic [15:0] dout;
    logic [15:0] faddr;
  } cyc_t;

  cyc_t         exp_q[$];
  cyc_t         r;
  cyc_t         c;
  logic [255:0] vr_model   = '0;
  logic [255:0] vr_pending = '0;
  logic [15:0]  ea;

  function automatic cyc_t idle_cyc();
    cyc_t x;
    x.rd = 0; x.wr = 0; x.vd = 0; x.fv = 0; x.chk_vr = 1; x.ld_done = 0;
    x.addr = '0; x.dout = '0; x.faddr = '0;
    return x;
  endfunction

  always @(negedge Clk1) begin
    if (!Reset) begin
      check("rst_addr", bus.Addr, 0);
      check("rst_rd", bus.RD, 0);
      check("rst_wr", bus.WR, 0);
      check("rst_dout", bus.dataOut, 0);
      check("rst_fetch_gnt", fetch_gnt, 0);
      check("rst_fetch_valid", fetch_valid, 0);
      check("rst_fetch_data", fetch_data, 0);
      check("rst_vdone", vdone, 0);
      check("rst_vrdata", vrdata, 0);
      exp_q.delete();
      vr_model = '0;
    end else if (exp_q.size() != 0) begin
      r = exp_q.pop_front();
      check("busy_vready", vready, 0);
      check("busy_fetch_gnt", fetch_gnt, 0);
      check("bus_rd", bus.RD, r.rd);
      check("bus_wr", bus.WR, r.wr);
      check("bus_addr", bus.Addr, r.addr);
      check("bus_dout", bus.dataOut, r.dout);
      check("vdone", vdone, r.vd);
      check("fetch_valid", fetch_valid, r.fv);
      check("fetch_data", fetch_data, r.fv ? ref_mem[r.faddr] : 16'h0);
      if (r.wr) ref_mem[r.addr] = r.dout;
      if (r.ld_done) vr_model = vr_pending;
      if (r.chk_vr) check("vrdata", vrdata, vr_model);
    end else begin
      check("idle_vready", vready, 1);
      check("idle_rd", bus.RD, 0);
      check("idle_wr", bus.WR, 0);
      check("idle_addr", bus.Addr, 0);
      check("idle_dout", bus.dataOut, 0);
      check("idle_vdone", vdone, 0);
      check("idle_fetch_valid", fetch_valid, 0);
      check("idle_fetch_data", fetch_data, 0);
      check("idle_vrdata", vrdata, vr_model);
      check("idle_fetch_gnt", fetch_gnt, fetch_req && !vreq);
      if (vreq) begin
        for (int k = 0; k < ELEMS; k++) begin
          c  = idle_cyc();
          ea = vbase + 16'(k);
          c.addr = ea;
          if (vwrite) begin
            c.wr   = 1;
            c.dout = vwdata[k*EW +: EW];
          end else begin
            c.rd     = 1;
            c.chk_vr = 0;
            vr_pending[k*EW +: EW] = ref_mem[ea];
          end
          exp_q.push_back(c);
        end
        if (!vwrite) begin
          c = idle_cyc();
          c.chk_vr = 0;
          exp_q.push_back(c);
        end
        c = idle_cyc();
        c.vd = 1;
        c.ld_done = !vwrite;
        exp_q.push_back(c);
      end else if (fetch_req) begin
        c = idle_cyc();
        c.rd = 1;
        c.addr = fetch_addr;
        exp_q.push_back(c);
        c = idle_cyc();
        c.fv = 1;
        c.faddr = fetch_addr;
        exp_q.push_back(c);
      end
    end
  end

  task automatic tick();
    @(posedge Clk1);
    #1;
  endtask

  function automatic logic [255:0] rand_vec();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!vready && n < 100) begin
      tick();
      n++;
    end
    check("ready_bound", vready, 1);
  endtask

  // lat: cycle index (accept cycle = 0) in which vdone is seen
  task automatic do_vec(input logic w, input logic [15:0] base,
                        input logic [255:0] data, output int lat);
    wait_ready();
    vreq = 1; vwrite = w; vbase = base; vwdata = data;
    tick();
    vreq = 0;
    lat = 1;
    while (!vdone && lat < 40) begin
      tick();
      lat++;
    end
    check("vdone_bound", vdone, 1);
  endtask

  task automatic do_fetch(input logic [15:0] a, input bit noise, output int gwait,
                          output int lat, output logic [15:0] data);
    fetch_req = 1; fetch_addr = a; gwait = 0;
    #1;
    while (!fetch_gnt && gwait < 100) begin
      tick();
      #1;
      gwait++;
    end
    check("fetch_gnt_bound", fetch_gnt, 1);
    tick();
    fetch_req = 0;
    fetch_addr = 16'($urandom);
    if (noise) begin
      vreq = 1; vwrite = 1'($urandom_range(0, 1)); vbase = 16'($urandom);
    end
    tick();
    vreq = 0;
    lat = 2;
    while (!fetch_valid && lat < 10) begin
      tick();
      lat++;
    end
    data = fetch_data;
  endtask

  task automatic do_both(input logic w, input logic [15:0] vb, input logic [255:0] vd,
                         input logic [15:0] fa, output int gap, output logic [15:0] data);
    int n, dn, gn, cnt;
    wait_ready();
    fetch_req = 1; fetch_addr = fa;
    vreq = 1; vwrite = w; vbase = vb; vwdata = vd;
    #1 check("both_gnt_c0", fetch_gnt, 0);
    tick();
    vreq = 0;
    n = 1; dn = -100; gn = -1;
    while (n < 60) begin
      #1;
      if (vdone) dn = n;
      if (fetch_gnt) begin
        gn = n;
        break;
      end
      tick();
      n++;
    end
    check("both_gnt_seen", gn >= 0, 1);
    gap = gn - dn;
    tick();
    fetch_req = 0;
    cnt = 0;
    while (!fetch_valid && cnt < 10) begin
      tick();
      cnt++;
    end
    data = fetch_data;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat, gw, gap;
    logic [15:0] d;
    logic [255:0] v;

    for (int i = 0; i < 65536; i++) begin
      mem_arr[i] = 16'(i) ^ 16'h5A5A;
      ref_mem[i] = 16'(i) ^ 16'h5A5A;
    end
    mem_arr[16'h0010] = 16'hBEEF;
    ref_mem[16'h0010] = 16'hBEEF;
    for (int i = 0; i < 16; i++) begin
      mem_arr[16'h0100 + i] = 16'(i + 1);
      ref_mem[16'h0100 + i] = 16'(i + 1);
    end

    // reset with every request input high
    Reset = 0; fetch_req = 1; vreq = 1; vwrite = 1;
    fetch_addr = '1; vbase = '1; vwdata = '1;
    repeat (3) @(posedge Clk1);
    #1;
    check("in_rst_gnt", fetch_gnt, 0);
    check("in_rst_rd", bus.RD, 0);
    Reset = 1;
    #1;
    check("release_gnt", fetch_gnt, 0);
    check("release_vready", vready, 1);
    tick();
    vreq = 0; fetch_req = 0; vwrite = 0;
    wait_ready();

    // single fetch
    do_fetch(16'h0010, 0, gw, lat, d);
    check("fetch_gnt_cycle", gw, 0);
    check("fetch_latency", lat, 2);
    check("fetch_data_beef", d, 16'hBEEF);

    // VLD from 0x0100
    do_vec(0, 16'h0100, rand_vec(), lat);
    check("vld_latency", lat, 18);
    for (int i = 0; i < 16; i++)
      check($sformatf("vld_elem%0d", i), vrdata[i*16 +: 16], 16'(i + 1));

    // VST wrapping from 0xFFF8
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'hA000 + 16'(i);
    do_vec(1, 16'hFFF8, v, lat);
    check("vst_latency", lat, 17);
    check("vst_mem_fff8", mem_arr[16'hFFF8], 16'hA000);
    check("vst_mem_ffff", mem_arr[16'hFFFF], 16'hA007);
    check("vst_mem_0000", mem_arr[16'h0000], 16'hA008);
    check("vst_mem_0007", mem_arr[16'h0007], 16'hA00F);
    check("vst_keeps_vrdata", vrdata[3*16 +: 16], 16'h0004);

    // simultaneous vreq and fetch_req
    do_both(0, 16'h0100, rand_vec(), 16'h0010, gap, d);
    check("both_gnt_after_vdone", gap, 1);
    check("both_fetch_data", d, 16'hBEEF);

    // reset during VSTORE at k=5
    wait_ready();
    for (int i = 0; i < 16; i++) v[i*16 +: 16] = 16'hC000 + 16'(i);
    vreq = 1; vwrite = 1; vbase = 16'h2000; vwdata = v;
    tick();
    vreq = 0; vwrite = 0;
    repeat (5) tick();
    check("abort_pre_wr", bus.WR, 1);
    check("abort_pre_addr", bus.Addr, 16'h2005);
    Reset = 0;
    #1;
    check("abort_wr", bus.WR, 0);
    check("abort_addr", bus.Addr, 0);
    check("abort_dout", bus.dataOut, 0);
    repeat (2) tick();
    Reset = 1;
    #1;
    check("abort_vready", vready, 1);
    check("abort_mem_2000", mem_arr[16'h2000], 16'hC000);
    check("abort_mem_2004", mem_arr[16'h2004], 16'hC004);
    check("abort_mem_2005", mem_arr[16'h2005], 16'h7A5F);

    // randomized traffic
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_fetch(16'($urandom), 1'($urandom_range(0, 1)), gw, lat, d);
        4, 5, 6, 7: do_vec(1'($urandom_range(0, 1)), 16'($urandom), rand_vec(), lat);
        8:          do_both(1'($urandom_range(0, 1)), 16'($urandom), rand_vec(),
                            16'($urandom), gap, d);
        default:    repeat ($urandom_range(1, 3)) tick();
      endcase
    end

    repeat (4) tick();
    begin
      int bad = 0;
      for (int i = 0; i < 65536; i++)
        if (mem_arr[i] !== ref_mem[i]) bad++;
      check("mem_image", bad, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
